// File: rtl/rv_sig_pkg.sv
// rv_sig_pkg: shared types and default constants for the signature compactor.
//   state_e  : compactor FSM states
//   DEF_POLY : default MISR feedback polynomial (CRC-32)
//   DEF_SEED : default signature value loaded on start
package rv_sig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        SHIFT = 2'd3
    } state_e;

    localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_SEED = 32'h0000_0000;

endpackage

// File: rtl/rv_sig_compactor_if.sv
// rv_sig_compactor_if: control, channel and result bundle of the compactor.
//   master : drives ch_data/ch_valid/start/stop/run_len/rd_req, observes results
//   slave  : the compactor side
// Build option SIG_CH_MASK_EN adds ch_mask_in (per-channel enable latched on start).
interface rv_sig_compactor_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     start;
    logic                     stop;
    logic [CNT_W-1:0]         run_len;
    logic                     rd_req;
`ifdef SIG_CH_MASK_EN
    logic [NUM_CH-1:0]        ch_mask_in;
`endif
    logic                     busy;
    logic                     done;
    logic [DATA_W-1:0]        sig;
    logic                     sig_valid;
    logic                     ser_out;
    logic [CNT_W-1:0]         cycles;

`ifdef SIG_CH_MASK_EN
    modport master (output ch_data, ch_valid, start, stop, run_len, rd_req, ch_mask_in,
                    input  busy, done, sig, sig_valid, ser_out, cycles);
    modport slave  (input  ch_data, ch_valid, start, stop, run_len, rd_req, ch_mask_in,
                    output busy, done, sig, sig_valid, ser_out, cycles);
`else
    modport master (output ch_data, ch_valid, start, stop, run_len, rd_req,
                    input  busy, done, sig, sig_valid, ser_out, cycles);
    modport slave  (input  ch_data, ch_valid, start, stop, run_len, rd_req,
                    output busy, done, sig, sig_valid, ser_out, cycles);
`endif

endinterface

// File: rtl/rv_sig_fold.sv
// rv_sig_fold: combinational fold of NUM_CH channels into one DATA_W word.
//   ch_data_i : packed channels, channel i at [i*DATA_W +: DATA_W]
//   ch_en_i   : per-channel enable
//   fold_c_o  : XOR of enabled channels, channel i rotated left by i mod DATA_W
// Rotation keeps identical values on different channels from cancelling.
module rv_sig_fold #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 6
) (
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    output logic [DATA_W-1:0]        fold_c_o
);

    // Rotate left: upper half of the doubled word shifted by r.
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                               input int unsigned        r);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} << r;
        return dbl[2*DATA_W-1 -: DATA_W];
    endfunction

    always_comb begin
        fold_c_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_en_i[i]) begin
                fold_c_o = fold_c_o ^ rotl(ch_data_i[i*DATA_W +: DATA_W], i % DATA_W);
            end
        end
    end

endmodule

// File: rtl/rv_sig_compactor.sv
// rv_sig_compactor: windowed MISR over NUM_CH bus channels with serial readout.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/stop/run_len window control, ch_data/ch_valid inputs,
//                  rd_req readout request; busy/done/sig/sig_valid/ser_out/cycles
// Build option SIG_CH_MASK_EN: ch_mask_in is latched on start and gates ch_valid.
module rv_sig_compactor
    import rv_sig_pkg::*;
#(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       NUM_CH = 6,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(DEF_POLY),
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED),
    parameter int unsigned       CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rv_sig_compactor_if.slave    bus
);

    localparam int unsigned SH_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    run_len_q, run_len_d;
    logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
    logic                ser_q, ser_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   fold_en_c;
    logic [DATA_W-1:0]   fold_c;
    logic                load_c;

`ifdef SIG_CH_MASK_EN
    logic [NUM_CH-1:0]   mask_q, mask_d;
    assign fold_en_c = bus.ch_valid & mask_q;
`else
    assign fold_en_c = bus.ch_valid;
`endif

    rv_sig_fold #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_fold (
        .ch_data_i (bus.ch_data),
        .ch_en_i   (fold_en_c),
        .fold_c_o  (fold_c)
    );

    // Next-state, MISR, counters and registered-output decode.
    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        run_len_d = run_len_q;
        sh_cnt_d  = sh_cnt_q;
        ser_d     = ser_q;
        load_c    = 1'b0;
`ifdef SIG_CH_MASK_EN
        mask_d    = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                ser_d  = 1'b0;
                load_c = bus.start;
            end
            RUN: begin
                // The stop cycle is not compacted and beats the terminal count.
                if (bus.stop) begin
                    state_d = DONE;
                end else begin
                    sig_d = {sig_q[DATA_W-2:0], 1'b0}
                          ^ (sig_q[DATA_W-1] ? POLY : '0)
                          ^ fold_c;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if ((run_len_q != '0) && (cnt_d == run_len_q)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    load_c = 1'b1;
                end else if (bus.rd_req) begin
                    state_d  = SHIFT;
                    sh_cnt_d = '0;
                end
            end
            SHIFT: begin
                // DATA_W shift edges, then one edge back to IDLE with the pin low.
                if (sh_cnt_q == SH_W'(DATA_W)) begin
                    state_d = IDLE;
                    ser_d   = 1'b0;
                end else begin
                    ser_d    = sig_q[DATA_W-1];
                    sig_d    = {sig_q[DATA_W-2:0], 1'b0};
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            state_d   = RUN;
            sig_d     = SEED;
            cnt_d     = '0;
            run_len_d = bus.run_len;
`ifdef SIG_CH_MASK_EN
            mask_d    = bus.ch_mask_in;
`endif
        end

        busy_d = (state_d == RUN) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sig_q     <= '0;
            cnt_q     <= '0;
            run_len_q <= '0;
            sh_cnt_q  <= '0;
            ser_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIG_CH_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            run_len_q <= run_len_d;
            sh_cnt_q  <= sh_cnt_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SIG_CH_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sig_valid = done_q;
    assign bus.sig       = sig_q;
    assign bus.ser_out   = ser_q;
    assign bus.cycles    = cnt_q;

endmodule

// File: tb/tb_rv_sig_compactor.sv
// tb_rv_sig_compactor: directed and randomized checks of rv_sig_compactor.
// Two DUTs share stimulus: u_dut (SEED=0) and u_dut_seed (SEED=32'h80000000).
module tb_rv_sig_compactor;
    import rv_sig_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 6;
    localparam int unsigned CW = 16;
    localparam logic [31:0] SEED2 = 32'h8000_0000;

    logic        clk;
    logic        reset_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_sig;
    logic [31:0] m_sig2;
    int          m_cnt;
    logic [5:0]  m_mask;

    rv_sig_compactor_if #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW)) bus ();
    rv_sig_compactor_if #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW)) bus2 ();

    rv_sig_compactor #(
        .DATA_W(DW), .NUM_CH(NC), .POLY(DEF_POLY), .SEED(32'h0), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    rv_sig_compactor #(
        .DATA_W(DW), .NUM_CH(NC), .POLY(DEF_POLY), .SEED(SEED2), .CNT_W(CW)
    ) u_dut_seed (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    assign bus2.ch_data  = bus.ch_data;
    assign bus2.ch_valid = bus.ch_valid;
    assign bus2.start    = bus.start;
    assign bus2.stop     = bus.stop;
    assign bus2.run_len  = bus.run_len;
    assign bus2.rd_req   = bus.rd_req;
`ifdef SIG_CH_MASK_EN
    assign bus2.ch_mask_in = bus.ch_mask_in;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Reference: bit-wise rotation, polynomial multiply-by-x modulo POLY, XOR in fold.
    function automatic logic [31:0] m_rotl(input logic [31:0] d, input int r);
        logic [31:0] o;
        o = '0;
        for (int b = 0; b < 32; b++) o[(b + r) % 32] = d[b];
        return o;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [191:0] d,
                                           input logic [5:0] v);
        logic [31:0] f;
        logic [31:0] x;
        f = '0;
        for (int i = 0; i < int'(NC); i++) if (v[i]) f = f ^ m_rotl(d[i*32 +: 32], i);
        x = s << 1;
        if (s[31]) x = x ^ DEF_POLY;
        return x ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_window(input logic [15:0] rl, input logic rd);
        bus.start    = 1'b1;
        bus.rd_req   = rd;
        bus.run_len  = rl;
        bus.ch_valid = '0;
        bus.stop     = 1'b0;
        m_sig  = 32'h0;
        m_sig2 = SEED2;
        m_cnt  = 0;
`ifdef SIG_CH_MASK_EN
        m_mask = bus.ch_mask_in;
`endif
        tick();
        bus.start  = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic run_cycle(input logic [191:0] d, input logic [5:0] v);
        bus.ch_data  = d;
        bus.ch_valid = v;
        m_sig  = m_step(m_sig,  d, v & m_mask);
        m_sig2 = m_step(m_sig2, d, v & m_mask);
        m_cnt++;
        tick();
        bus.ch_valid = '0;
    endtask

    task automatic read_out(input logic [31:0] want, input int want_cnt);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        check("shift_busy", 64'(bus.busy), 64'(1));
        check("shift_done", 64'(bus.done), 64'(0));
        for (int k = 0; k < 32; k++) begin
            tick();
            check($sformatf("ser_bit%0d", k), 64'(bus.ser_out), 64'(want[31-k]));
        end
        check("shift_sig_zero", 64'(bus.sig), 64'(0));
        tick();
        check("post_ser_low", 64'(bus.ser_out), 64'(0));
        check("post_busy", 64'(bus.busy), 64'(0));
        check("post_done", 64'(bus.done), 64'(0));
        check("post_cycles_hold", 64'(bus.cycles), 64'(want_cnt));
    endtask

    initial begin
        int          len;
        logic        use_stop;
        logic [191:0] d;
        logic [5:0]  v;

        reset_n      = 1'b0;
        bus.ch_data  = '0;
        bus.ch_valid = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.run_len  = '0;
        bus.rd_req   = 1'b0;
        m_mask       = '1;
`ifdef SIG_CH_MASK_EN
        bus.ch_mask_in = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_sig", 64'(bus.sig), 64'(0));
        check("rst_cycles", 64'(bus.cycles), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sig_valid", 64'(bus.sig_valid), 64'(0));
        check("rst_ser", 64'(bus.ser_out), 64'(0));
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("idle_busy", 64'(bus.busy), 64'(0));

        // Single valid channel, one-cycle window
        begin_window(16'd1, 1'b0);
        check("run_busy", 64'(bus.busy), 64'(1));
        run_cycle({160'h0, 32'h0000_00A5}, 6'b000001);
        check("a5_sig", 64'(bus.sig), 64'h0000_00A5);
        check("a5_cycles", 64'(bus.cycles), 64'(1));
        check("a5_done", 64'(bus.done), 64'(1));
        check("a5_sig_valid", 64'(bus.sig_valid), 64'(1));
        check("a5_busy", 64'(bus.busy), 64'(0));

        // stop outside RUN has no effect
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("done_stop_done", 64'(bus.done), 64'(1));
        check("done_stop_sig", 64'(bus.sig), 64'h0000_00A5);

        // Equal data on two channels must not cancel
        begin_window(16'd1, 1'b0);
        run_cycle({128'h0, 32'h1, 32'h1}, 6'b000011);
        check("anticancel_2ch", 64'(bus.sig), 64'h3);

        // start wins over rd_req in DONE
        begin_window(16'd2, 1'b1);
        check("prio_busy", 64'(bus.busy), 64'(1));
        check("prio_done", 64'(bus.done), 64'(0));
        check("prio_sig_seed", 64'(bus.sig), 64'(0));
        check("prio_cycles", 64'(bus.cycles), 64'(0));
        run_cycle({160'h0, 32'h1}, 6'b000001);
        run_cycle({160'h0, 32'h1}, 6'b000001);
        check("anticancel_time", 64'(bus.sig), 64'h3);
        check("anticancel_cycles", 64'(bus.cycles), 64'(2));
        check("anticancel_done", 64'(bus.done), 64'(1));

        // Feedback from MSB of the seed
        begin_window(16'd1, 1'b0);
        run_cycle({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  6'b000000);
        check("feedback_seed", 64'(bus2.sig), 64'h04C1_1DB7);
        check("feedback_zero", 64'(bus.sig), 64'h0);

        // Early stop; the stop cycle is not folded
        begin_window(16'd0, 1'b0);
        repeat (3) run_cycle({160'h0, 32'h1}, 6'b000001);
        check("unbounded_busy", 64'(bus.busy), 64'(1));
        bus.ch_data  = {160'h0, 32'h1};
        bus.ch_valid = 6'b000001;
        bus.stop     = 1'b1;
        tick();
        bus.stop     = 1'b0;
        bus.ch_valid = '0;
        check("stop_cycles", 64'(bus.cycles), 64'(3));
        check("stop_sig", 64'(bus.sig), 64'h7);
        check("stop_done", 64'(bus.done), 64'(1));

        // Serial readout, MSB first
        begin_window(16'd1, 1'b0);
        run_cycle({160'h0, 32'hA500_0001}, 6'b000001);
        check("rd_sig", 64'(bus.sig), 64'hA500_0001);
        read_out(32'hA500_0001, 1);

        // Asynchronous reset in the middle of a window
        begin_window(16'd0, 1'b0);
        repeat (3) run_cycle({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom()}, 6'b111111);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_sig", 64'(bus.sig), 64'(0));
        check("midrst_cycles", 64'(bus.cycles), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("midrst_idle", 64'(bus.busy), 64'(0));

`ifdef SIG_CH_MASK_EN
        bus.ch_mask_in = 6'b000010;
        begin_window(16'd1, 1'b0);
        bus.ch_mask_in = '1;
        run_cycle({128'h0, 32'h1, 32'h1}, 6'b000011);
        check("mask_sig", 64'(bus.sig), 64'h2);
`endif

        // Randomized windows against the reference model
        for (int t = 0; t < 16; t++) begin
            len      = int'($urandom_range(1, 8));
            use_stop = 1'($urandom_range(0, 1));
            if (use_stop)
                begin_window(($urandom_range(0, 1) != 0) ? 16'h0 : CW'(len + 3), 1'b0);
            else
                begin_window(CW'(len), 1'b0);
            for (int k = 0; k < len; k++) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                v = 6'($urandom_range(0, 63));
                bus.start = 1'($urandom_range(0, 1));
                run_cycle(d, v);
                bus.start = 1'b0;
            end
            if (use_stop) begin
                bus.ch_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom()};
                bus.ch_valid = 6'($urandom_range(0, 63));
                bus.stop     = 1'b1;
                tick();
                bus.stop     = 1'b0;
                bus.ch_valid = '0;
            end
            check($sformatf("rand%0d_sig", t), 64'(bus.sig), 64'(m_sig));
            check($sformatf("rand%0d_sig_seed", t), 64'(bus2.sig), 64'(m_sig2));
            check($sformatf("rand%0d_cycles", t), 64'(bus.cycles), 64'(m_cnt));
            check($sformatf("rand%0d_done", t), 64'(bus.done), 64'(1));
            if ((t % 4) == 0) read_out(m_sig, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_sig_compactor.md
Name: rv_sig_compactor

Overview:
Parametrised multiple-input signature register (MISR) that compacts up to NUM_CH core/memory bus channels into one DATA_W-bit signature over a bounded capture window. It sits beside RV32I_Core, Instruction_Memory and Data_Memory in the FPGA top and replaces the free-running XOR sink. It adds start/stop control, a cycle counter, rotation per channel to prevent cancellation, CRC-style feedback and serial readout on one pin.

Parameters:
DATA_W, 32, channel and signature width
NUM_CH, 6, number of compacted channels
POLY, 32'h04C11DB7, MISR feedback polynomial; only the low DATA_W bits are used
SEED, 0, signature value loaded on start
CNT_W, 16, width of the window and cycle counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ch_data  in  NUM_CH*DATA_W  packed channels; channel i is at [i*DATA_W +: DATA_W]
ch_valid  in  NUM_CH  per-channel qualify for the current cycle
start  in  1  begin a capture window
stop  in  1  end the window early
run_len  in  CNT_W  number of compaction cycles; 0 means unbounded until stop
rd_req  in  1  request serial readout of the signature
busy  out  1  high in RUN or SHIFT
done  out  1  high in DONE
sig  out  DATA_W  current signature register
sig_valid  out  1  high in DONE
ser_out  out  1  serial signature bit, sent MSB first
cycles  out  CNT_W  compaction cycles performed, saturating

Behaviour:
- Reset is asynchronous and active-low: reset_n=0 (clk) forces state to IDLE and clears sig, cycles, busy, done, sig_valid and ser_out to 0. Reset mid-RUN or mid-SHIFT aborts with no residue.
- FSM states: IDLE, RUN, DONE, SHIFT.
- IDLE, start=1: on the next edge sig<=SEED, cycles<=0, state<=RUN. run_len is latched at this point.
- RUN, each edge with stop=0:
  - fold = XOR over i of (ch_valid[i] ? rotl(ch_i, i mod DATA_W) : 0).
  - sig <= {sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? POLY : 0) ^ fold.
  - cycles <= cycles+1, saturating at all-ones.
- RUN exit:
  - If the latched run_len is nonzero and this edge makes cycles equal run_len, state<=DONE.
  - stop=1 in RUN gives state<=DONE. The stop cycle is NOT compacted. stop has priority over the run_len terminal count.
- start is ignored in RUN and SHIFT. stop is ignored outside RUN.
- DONE: sig holds, sig_valid=1, done=1.
  - start=1 restarts as from IDLE.
  - Otherwise rd_req=1 gives state<=SHIFT.
  - start has priority over rd_req.
- SHIFT:
  - ser_out is registered as sig[DATA_W-1] and sig shifts left by 1 each edge, for exactly DATA_W cycles.
  - The first bit appears the cycle after SHIFT is entered.
  - Then state<=IDLE and ser_out<=0. sig ends at 0.
- cycles holds its value through DONE, SHIFT and IDLE until the next start.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
SIG_CH_MASK_EN
- Defined: adds input port ch_mask_in[NUM_CH-1:0]. It is latched into an internal mask on start, and only channels with both mask=1 and ch_valid=1 are folded. The mask resets to all-ones.
- Undefined: the port is absent and folding uses ch_valid alone.

Decomposition:
- Package rv_sig_pkg holds the state enum (IDLE/RUN/DONE/SHIFT) and the default POLY and SEED constants.
- One sub-module, rv_sig_fold: combinational rotate-and-XOR of NUM_CH channels into DATA_W bits.
- The FSM, MISR and counter stay in the top module.

Test Plan:
- Reset mid-RUN: assert reset_n=0 after 3 compaction cycles -> sig=0, cycles=0, busy=0, state IDLE.
- start, run_len=1, ch0=32'h000000A5 valid, others invalid -> sig=32'h000000A5, cycles=1, done=1 one cycle after the RUN edge.
- Anti-cancellation: run_len=1, ch0=ch1=32'h00000001 both valid -> sig=32'h00000003. run_len=2, ch0=1 only -> sig=32'h00000003.
- Feedback: SEED=32'h80000000, run_len=1, all ch_valid=0 -> sig=32'h04C11DB7.
- Early stop: run_len=0, ch0=1 valid, stop asserted on the 4th RUN cycle -> cycles=3, sig=32'h00000007, the stop-cycle data is not folded.
- Readout: from DONE with sig=32'hA5000001, pulse rd_req -> ser_out shows 1,0,1,0,0,1,0,1, then 23 zeros, then 1 over 32 cycles, then IDLE with ser_out=0. With SIG_CH_MASK_EN, ch_mask_in=6'b000010 and ch0=ch1=1 -> sig=32'h00000002.
